// File: rtl/multi_cycle_datapath.sv
// Multi-cycle RV32 datapath: FETCH/DECODE/EXEC/MEM/WB with ready-handshaked memories.
// Define MCD_BRANCH_EN to enable branch resolution and JAL (PC+imm, PC+4 writeback).
module multi_cycle_datapath #(
  parameter int PC_W       = 8,
  parameter int INS_W      = 32,
  parameter int RF_ADDRESS = 5,
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int ALU_CC_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic                  mem2reg,
  input  logic                  alu_src,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic                  branch,
  input  logic                  jump,
  input  logic [ALU_CC_W-1:0]   alu_cc,
  input  logic [INS_W-1:0]      imem_rdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ready,
  output logic [6:0]            opcode,
  output logic [6:0]            funct7,
  output logic [2:0]            funct3,
  output logic [DATA_W-1:0]     alu_result,
  output logic [PC_W-1:0]       imem_addr,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DM_ADDRESS-1:0] dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  output logic [PC_W-1:0]       pc_out,
  output logic                  retire
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB
  } state_t;

  state_t state, state_nx;

  logic [INS_W-1:0]      ir;
  logic [DATA_W-1:0]     a_q, b_q, alu_q, mdr_q;
  logic [DATA_W-1:0]     imm, alu_b, alu_y, wb_data;
  logic [DATA_W-1:0]     rf [2**RF_ADDRESS];
  logic [PC_W-1:0]       pc, pc_seq, pc_raw, pc_nx;
  logic [RF_ADDRESS-1:0] rs1, rs2, rd;
  logic                  is_s, is_b, is_j;
  logic                  br_ex, jump_wb;

  assign rs1 = ir[15 +: RF_ADDRESS];
  assign rs2 = ir[20 +: RF_ADDRESS];
  assign rd  = ir[7 +: RF_ADDRESS];

  assign is_s = ir[6:0] == 7'b0100011;
  assign is_b = ir[6:0] == 7'b1100011;
  assign is_j = ir[6:0] == 7'b1101111;

  always_comb begin
    imm = DATA_W'($signed(ir[31:20]));
    unique case (1'b1)
      is_s: imm = DATA_W'($signed({ir[31:25], ir[11:7]}));
      is_b: imm = DATA_W'($signed({ir[31], ir[7], ir[30:25],
                                   ir[11:8], 1'b0}));
      is_j: imm = DATA_W'($signed({ir[31], ir[19:12], ir[20],
                                   ir[30:21], 1'b0}));
      default: ;
    endcase
  end

  assign alu_b = alu_src ? imm : b_q;

  always_comb begin
    alu_y = '0;
    unique case (alu_cc)
      4'b0000: alu_y = a_q & alu_b;
      4'b0001: alu_y = a_q | alu_b;
      4'b0010: alu_y = a_q + alu_b;
      4'b0011: alu_y = a_q ^ alu_b;
      4'b0110: alu_y = a_q - alu_b;
      4'b0111: alu_y = DATA_W'($signed(a_q) < $signed(alu_b));
      4'b1000: alu_y = DATA_W'(a_q < alu_b);
      4'b1100: alu_y = ~(a_q | alu_b);
      default: alu_y = '0;
    endcase
  end

  assign pc_seq = pc + PC_W'(4);

`ifdef MCD_BRANCH_EN
  logic take;
  // Branch resolves in EXEC from the live ALU result, before ALUOut lands.
  assign take = (state == EXEC && branch &&
                 ((alu_y == '0) ^ ir[12])) ||
                (state == WB && jump);
  assign pc_raw  = take ? pc + imm[PC_W-1:0] : pc_seq;
  assign br_ex   = branch & ~jump;
  assign jump_wb = jump;
`else
  logic unused_ctl;
  assign unused_ctl = branch ^ jump;
  assign pc_raw     = pc_seq;
  assign br_ex      = 1'b0;
  assign jump_wb    = 1'b0;
`endif

  assign pc_nx   = {pc_raw[PC_W-1:2], 2'b00};
  assign wb_data = jump_wb ? DATA_W'(pc_seq)
                 : (mem2reg ? mdr_q : alu_q);

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    unique case (state)
      FETCH:  state_nx = DECODE;
      DECODE: state_nx = EXEC;
      EXEC: begin
        if (mem_read || mem_write) begin
          state_nx = MEM;
        end else if (br_ex) begin
          retire   = 1'b1;
          state_nx = FETCH;
        end else begin
          state_nx = WB;
        end
      end
      MEM: begin
        if (dmem_ready) begin
          if (mem_write) begin
            retire   = 1'b1;
            state_nx = FETCH;
          end else begin
            state_nx = WB;
          end
        end
      end
      WB: begin
        retire   = 1'b1;
        state_nx = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      pc    <= '0;
      for (int i = 0; i < 2**RF_ADDRESS; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        FETCH:  ir <= imem_rdata;
        DECODE: begin
          a_q <= (rs1 == '0) ? '0 : rf[rs1];
          b_q <= (rs2 == '0) ? '0 : rf[rs2];
        end
        EXEC:   alu_q <= alu_y;
        MEM:    if (dmem_ready && !mem_write) mdr_q <= dmem_rdata;
        WB:     if (reg_write && rd != '0) rf[rd] <= wb_data;
        default: ;
      endcase
      if (retire) pc <= pc_nx;
    end
  end

  assign opcode     = ir[6:0];
  assign funct3     = ir[14:12];
  assign funct7     = ir[31:25];
  assign alu_result = alu_q;
  assign imem_addr  = pc;
  assign pc_out     = pc;
  assign dmem_req   = state == MEM;
  assign dmem_we    = dmem_req & mem_write;
  assign dmem_addr  = alu_q[DM_ADDRESS-1:0];
  assign dmem_wdata = b_q;

endmodule

// File: tb/tb_multi_cycle_datapath.sv
// Directed-vector bench for multi_cycle_datapath.
// Expected values are hand-computed per instruction.
module tb_multi_cycle_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write, mem2reg, alu_src, mem_write, mem_read;
  logic        branch, jump;
  logic [3:0]  alu_cc;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        dmem_ready;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] alu_result, dmem_wdata;
  logic [7:0]  imem_addr, pc_out;
  logic        dmem_req, dmem_we, retire;
  logic [8:0]  dmem_addr;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] C_ALUI  = 7'b1010000;
  localparam logic [6:0] C_ALUR  = 7'b1000000;
  localparam logic [6:0] C_LOAD  = 7'b1110100;
  localparam logic [6:0] C_STORE = 7'b0011000;
  localparam logic [6:0] C_BR    = 7'b0000010;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;

  multi_cycle_datapath dut (
    .clk(clk), .reset(reset),
    .reg_write(reg_write), .mem2reg(mem2reg), .alu_src(alu_src),
    .mem_write(mem_write), .mem_read(mem_read),
    .branch(branch), .jump(jump), .alu_cc(alu_cc),
    .imem_rdata(imem_rdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .alu_result(alu_result), .imem_addr(imem_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .pc_out(pc_out), .retire(retire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Entered during a FETCH cycle before its falling edge; returns
  // just after the retire edge, i.e. inside the next FETCH cycle.
  task automatic run(input logic [31:0] ins, input logic [6:0] ctl,
                     input logic [3:0] cc, input int w,
                     input logic [31:0] rdat,
                     output int cyc, output int nreq,
                     output logic [31:0] addr,
                     output logic [31:0] wd, output logic we);
    imem_rdata = ins;
    {reg_write, mem2reg, alu_src, mem_write, mem_read,
     branch, jump} = ctl;
    alu_cc     = cc;
    dmem_rdata = rdat;
    dmem_ready = 1'b0;
    cyc = 0; nreq = 0; addr = '0; wd = '0; we = 1'b0;
    for (int c = 1; c <= 60 && cyc == 0; c++) begin
      @(negedge clk);
      if (dmem_req) begin
        nreq++;
        addr = 32'(dmem_addr);
        wd   = dmem_wdata;
        we   = dmem_we;
        dmem_ready = (nreq > w);
      end
      #1;
      if (retire) cyc = c;
    end
    @(posedge clk);
    #1;
    dmem_ready = 1'b0;
  endtask

  logic [3:0]  ops  [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011,
                            4'b0110, 4'b0111, 4'b1000, 4'b1100,
                            4'b0101};
  logic [31:0] opx  [9] = '{32'h00000005, 32'hDEADBEEF,
                            32'hDEADBEF4, 32'hDEADBEEA,
                            32'hDEADBEEA, 32'h00000001,
                            32'h00000000, 32'h21524110,
                            32'h00000000};

  initial begin
    int          cyc, nreq;
    logic [31:0] addr, wd;
    logic        we;
    logic [7:0]  exp_pc;
    int          br_cyc;

    reset = 1'b0;
    {reg_write, mem2reg, alu_src, mem_write, mem_read,
     branch, jump} = '0;
    alu_cc = '0; imem_rdata = '0; dmem_rdata = '0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_alu", alu_result, 32'h0);
    chk("rst_retire", 32'(retire), 32'h0);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    // addi x1,x0,5
    run(32'h00500093, C_ALUI, ADD, 0, 0, cyc, nreq, addr, wd, we);
    chk("addi_cyc", 32'(cyc), 32'd4);
    chk("addi_alu", alu_result, 32'd5);
    chk("addi_pc", 32'(pc_out), 32'h04);

    // add x5,x1,x0 reads x1 back
    run(32'h000082B3, C_ALUR, ADD, 0, 0, cyc, nreq, addr, wd, we);
    chk("x1_val", alu_result, 32'd5);
    chk("add_pc", 32'(pc_out), 32'h08);

    // lw x2,0(x0) with 3 wait states
    run(32'h00002103, C_LOAD, ADD, 3, 32'hDEADBEEF,
        cyc, nreq, addr, wd, we);
    chk("lw_cyc", 32'(cyc), 32'd8);
    chk("lw_req", 32'(nreq), 32'd4);
    chk("lw_addr", addr, 32'h0);
    chk("lw_we", 32'(we), 32'h0);
    chk("lw_opcode", 32'(opcode), 32'h03);
    chk("lw_pc", 32'(pc_out), 32'h0C);

    // add x6,x2,x0 reads x2 back
    run(32'h00010333, C_ALUR, ADD, 0, 0, cyc, nreq, addr, wd, we);
    chk("x2_val", alu_result, 32'hDEADBEEF);

    // sw x1,4(x0), ready on first MEM cycle
    run(32'h00102223, C_STORE, ADD, 0, 0, cyc, nreq, addr, wd, we);
    chk("sw_cyc", 32'(cyc), 32'd4);
    chk("sw_req", 32'(nreq), 32'd1);
    chk("sw_addr", addr, 32'h4);
    chk("sw_wdata", wd, 32'd5);
    chk("sw_we", 32'(we), 32'h1);
    chk("sw_pc", 32'(pc_out), 32'h14);

    // R-type on x2 (0xDEADBEEF) and x1 (5) across all ALU codes
    exp_pc = 8'h14;
    for (int i = 0; i < 9; i++) begin
      run(32'h001103B3, C_ALUR, ops[i], 0, 0,
          cyc, nreq, addr, wd, we);
      exp_pc = exp_pc + 8'd4;
      chk($sformatf("alu%0d", i), alu_result, opx[i]);
    end
    chk("alu_pc", 32'(pc_out), 32'(exp_pc));

    // beq x0,x0,+8
    run(32'h00000463, C_BR, SUB, 0, 0, cyc, nreq, addr, wd, we);
`ifdef MCD_BRANCH_EN
    br_cyc = 3;
    exp_pc = exp_pc + 8'd8;
`else
    br_cyc = 4;
    exp_pc = exp_pc + 8'd4;
`endif
    chk("br_cyc", 32'(cyc), 32'(br_cyc));
    chk("br_pc", 32'(pc_out), 32'(exp_pc));
    chk("br_zero", alu_result, 32'h0);

    // Reset while a load is stalled in MEM
    imem_rdata = 32'h00002103;
    {reg_write, mem2reg, alu_src, mem_write, mem_read,
     branch, jump} = C_LOAD;
    alu_cc = ADD;
    dmem_ready = 1'b0;
    for (int c = 0; c < 10 && !dmem_req; c++) @(negedge clk);
    chk("mid_req_up", 32'(dmem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("mid_req_drop", 32'(dmem_req), 32'h0);
    chk("mid_pc", 32'(pc_out), 32'h0);
    chk("mid_retire", 32'(retire), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    run(32'h000082B3, C_ALUR, ADD, 0, 0, cyc, nreq, addr, wd, we);
    chk("mid_x1", alu_result, 32'h0);
    chk("mid_cyc", 32'(cyc), 32'd4);
    chk("mid_pc4", 32'(pc_out), 32'h04);

    // addi x0,x0,7 until PC reaches 0xFC, then once more to wrap
    for (int k = 0; k < 80 && pc_out != 8'hFC; k++)
      run(32'h00700013, C_ALUI, ADD, 0, 0, cyc, nreq, addr, wd, we);
    chk("wrap_pre", 32'(pc_out), 32'hFC);
    run(32'h00700013, C_ALUI, ADD, 0, 0, cyc, nreq, addr, wd, we);
    chk("wrap_alu", alu_result, 32'd7);
    chk("wrap_pc", 32'(pc_out), 32'h00);
    run(32'h000002B3, C_ALUR, ADD, 0, 0, cyc, nreq, addr, wd, we);
    chk("x0_zero", alu_result, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
